reg_pending_scoreboard: RTL and testbench

//   Tracks registers that have an outstanding (issued, not yet written back) write.

---
 rtl/reg_pending_scoreboard.sv | 86 ++++++++
 tb/tb_reg_pending_scoreboard.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_pending_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register with an outstanding write.
// Stalls issue on RAW/WAW hazards and frees entries as writebacks complete.
module reg_pending_scoreboard #(
    parameter int ADDR_W         = 5,
    parameter bit ZERO_HARDWIRED = 1'b1
) (
    input  logic                     clock,
    input  logic                     ctrl_reset_n,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [ADDR_W-1:0]        issue_rd,
    input  logic                     issue_rd_we,
    input  logic [ADDR_W-1:0]        issue_rs1,
    input  logic                     issue_rs1_used,
    input  logic [ADDR_W-1:0]        issue_rs2,
    input  logic                     issue_rs2_used,
    input  logic                     wb_valid,
    input  logic [ADDR_W-1:0]        wb_rd,
    output logic [(2**ADDR_W)-1:0]   pending,
    output logic [ADDR_W:0]          pending_count,
    output logic                     wb_err
);

    localparam int NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0]   ZERO    = '0;
    localparam logic [NUM_REGS-1:0] ONE_HOT = NUM_REGS'(1);
    localparam logic [ADDR_W:0]     CNT_ONE = (ADDR_W+1)'(1);

    logic [NUM_REGS-1:0] r_pending;
    logic [ADDR_W:0]     r_count;
    logic                r_wb_err;

    logic                w_rs1_hz;
    logic                w_rs2_hz;
    logic                w_rd_hz;
    logic                w_accept;
    logic                w_set;
    logic                w_clr;
    logic                w_err_nxt;
    logic [NUM_REGS-1:0] w_set_oh;
    logic [NUM_REGS-1:0] w_clr_oh;

    // A same-cycle writeback to a pending register frees it for this issue.
    function automatic logic f_busy(input logic [ADDR_W-1:0] r);
        return r_pending[r]
            & ~(wb_valid & (wb_rd == r))
            & ~(ZERO_HARDWIRED & (r == ZERO));
    endfunction

    always_comb begin
        w_rs1_hz  = issue_rs1_used & f_busy(issue_rs1);
        w_rs2_hz  = issue_rs2_used & f_busy(issue_rs2);
        w_rd_hz   = issue_rd_we & f_busy(issue_rd);
        w_accept  = issue_valid & ~(w_rs1_hz | w_rs2_hz | w_rd_hz);
        w_set     = w_accept & issue_rd_we
                  & ~(ZERO_HARDWIRED & (issue_rd == ZERO));
        w_clr     = wb_valid & r_pending[wb_rd];
        w_err_nxt = wb_valid & ~r_pending[wb_rd]
                  & ~(ZERO_HARDWIRED & (wb_rd == ZERO));
        w_set_oh  = w_set ? (ONE_HOT << issue_rd) : '0;
        w_clr_oh  = w_clr ? (ONE_HOT << wb_rd) : '0;
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_pending <= '0;
            r_count   <= '0;
            r_wb_err  <= 1'b0;
        end else begin
            // Set is ORed in after the clear, so it wins on the same register.
            r_pending <= (r_pending & ~w_clr_oh) | w_set_oh;
            r_wb_err  <= w_err_nxt;
            unique case ({w_set, w_clr})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign issue_ready   = ~(w_rs1_hz | w_rs2_hz | w_rd_hz);
    assign pending       = r_pending;
    assign pending_count = r_count;
    assign wb_err        = r_wb_err;

endmodule

// File: tb/tb_reg_pending_scoreboard.sv
// Directed bench for reg_pending_scoreboard: ADDR_W=5 and ADDR_W=3 instances.
module tb_reg_pending_scoreboard;

    logic clock = 1'b0;
    logic ctrl_reset_n = 1'b0;

    logic        issue_valid, issue_ready, issue_rd_we;
    logic        issue_rs1_used, issue_rs2_used, wb_valid, wb_err;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2, wb_rd;
    logic [31:0] pending;
    logic [5:0]  pending_count;

    logic        b_valid, b_ready, b_rd_we, b_rs1_used, b_rs2_used;
    logic        b_wb_valid, b_wb_err;
    logic [2:0]  b_rd, b_rs1, b_rs2, b_wb_rd;
    logic [7:0]  b_pending;
    logic [3:0]  b_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    reg_pending_scoreboard #(.ADDR_W(5), .ZERO_HARDWIRED(1'b1)) u_dut (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
        .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
        .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .pending(pending), .pending_count(pending_count), .wb_err(wb_err)
    );

    reg_pending_scoreboard #(.ADDR_W(3), .ZERO_HARDWIRED(1'b1)) u_dut3 (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n),
        .issue_valid(b_valid), .issue_ready(b_ready),
        .issue_rd(b_rd), .issue_rd_we(b_rd_we),
        .issue_rs1(b_rs1), .issue_rs1_used(b_rs1_used),
        .issue_rs2(b_rs2), .issue_rs2_used(b_rs2_used),
        .wb_valid(b_wb_valid), .wb_rd(b_wb_rd),
        .pending(b_pending), .pending_count(b_count), .wb_err(b_wb_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd_we = 0; issue_rd = 0;
        issue_rs1 = 0; issue_rs1_used = 0;
        issue_rs2 = 0; issue_rs2_used = 0;
        wb_valid = 0; wb_rd = 0;
        b_valid = 0; b_rd_we = 0; b_rd = 0;
        b_rs1 = 0; b_rs1_used = 0; b_rs2 = 0; b_rs2_used = 0;
        b_wb_valid = 0; b_wb_rd = 0;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1; issue_rd_we = 1; issue_rd = rd;
    endtask

    initial begin
        idle();
        #2;
        chk("rst_pending", pending, 32'h0);
        chk("rst_count", 32'(pending_count), 32'h0);
        chk("rst_ready", 32'(issue_ready), 32'h1);
        #10 ctrl_reset_n = 1'b1;
        step();

        // 1: reset mid-run with pending=0x6
        issue(5'd1); step();
        issue(5'd2); step();
        idle(); #1;
        chk("t1_pending_pre", pending, 32'h6);
        chk("t1_count_pre", 32'(pending_count), 32'd2);
        issue_rs1 = 5'd1; issue_rs1_used = 1; issue_valid = 1;
        #1;
        chk("t1_stall_pre", 32'(issue_ready), 32'h0);
        #1 ctrl_reset_n = 1'b0;
        #1;
        chk("t1_rst_pending", pending, 32'h0);
        chk("t1_rst_count", 32'(pending_count), 32'h0);
        chk("t1_rst_err", 32'(wb_err), 32'h0);
        chk("t1_rst_ready", 32'(issue_ready), 32'h1);
        idle();
        step();
        #2 ctrl_reset_n = 1'b1;
        step();

        // 2: RAW stall then writeback
        issue(5'd5); #1;
        chk("t2_ready_first", 32'(issue_ready), 32'h1);
        step();
        chk("t2_pending", pending, 32'h20);
        chk("t2_count", 32'(pending_count), 32'd1);
        idle();
        issue_valid = 1; issue_rs1 = 5'd5; issue_rs1_used = 1; #1;
        chk("t2_raw_rs1", 32'(issue_ready), 32'h0);
        issue_rs1_used = 0; issue_rs2 = 5'd5; issue_rs2_used = 1; #1;
        chk("t2_raw_rs2", 32'(issue_ready), 32'h0);
        issue_rd = 5'd4; issue_rd_we = 1; step();
        chk("t2_stalled_noset", pending, 32'h20);
        idle();
        wb_valid = 1; wb_rd = 5'd5; step();
        idle();
        chk("t2_wb_pending", pending, 32'h0);
        chk("t2_wb_count", 32'(pending_count), 32'd0);
        chk("t2_wb_err", 32'(wb_err), 32'h0);

        // 3: bypass + set-wins on r7
        issue(5'd7); step();
        chk("t3_pending_pre", pending, 32'h80);
        wb_valid = 1; wb_rd = 5'd7; #1;
        chk("t3_bypass_ready", 32'(issue_ready), 32'h1);
        step();
        idle();
        chk("t3_pending", pending, 32'h80);
        chk("t3_count", 32'(pending_count), 32'd1);
        chk("t3_err", 32'(wb_err), 32'h0);
        wb_valid = 1; wb_rd = 5'd7; step();
        idle();
        chk("t3_clean", pending, 32'h0);

        // 4: zero register
        issue(5'd0); issue_rs1 = 5'd0; issue_rs1_used = 1; #1;
        chk("t4_ready", 32'(issue_ready), 32'h1);
        step();
        idle();
        chk("t4_pending", pending, 32'h0);
        chk("t4_count", 32'(pending_count), 32'd0);
        wb_valid = 1; wb_rd = 5'd0; step();
        idle();
        chk("t4_err", 32'(wb_err), 32'h0);
        chk("t4_pending_wb", pending, 32'h0);

        // 5: spurious writeback, WAW stall, invalid issue
        issue(5'd3); step();
        idle();
        wb_valid = 1; wb_rd = 5'd9; step();
        idle();
        chk("t5_err_pulse", 32'(wb_err), 32'h1);
        chk("t5_pending", pending, 32'h8);
        chk("t5_count", 32'(pending_count), 32'd1);
        issue(5'd3); #1;
        chk("t5_waw_stall", 32'(issue_ready), 32'h0);
        idle();
        issue_rd = 5'd4; issue_rd_we = 1; issue_valid = 0; step();
        idle();
        chk("t5_err_gone", 32'(wb_err), 32'h0);
        chk("t5_novalid", pending, 32'h8);
        wb_valid = 1; wb_rd = 5'd3; step();
        idle();
        chk("t5_clean", pending, 32'h0);

        // 6: ADDR_W=3 fill, drain, simultaneous set/clear
        for (int r = 1; r < 8; r++) begin
            b_valid = 1; b_rd_we = 1; b_rd = 3'(r); #1;
            chk("t6_fill_ready", 32'(b_ready), 32'h1);
            step();
        end
        idle();
        chk("t6_full_count", 32'(b_count), 32'd7);
        chk("t6_full_pending", 32'(b_pending), 32'hFE);
        b_valid = 1; b_rd_we = 1; b_rd = 3'd1; #1;
        chk("t6_waw_full", 32'(b_ready), 32'h0);
        step();
        idle();
        chk("t6_count_hold", 32'(b_count), 32'd7);
        for (int r = 1; r < 8; r++) begin
            b_wb_valid = 1; b_wb_rd = 3'(r); step();
        end
        idle();
        chk("t6_drain_count", 32'(b_count), 32'd0);
        chk("t6_drain_pending", 32'(b_pending), 32'h0);
        chk("t6_drain_err", 32'(b_wb_err), 32'h0);
        b_valid = 1; b_rd_we = 1; b_rd = 3'd2; step();
        idle();
        b_valid = 1; b_rd_we = 1; b_rd = 3'd3;
        b_wb_valid = 1; b_wb_rd = 3'd2; step();
        idle();
        chk("t6_swap_count", 32'(b_count), 32'd1);
        chk("t6_swap_pending", 32'(b_pending), 32'h08);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
